// File: rtl/led_bank_arbiter.sv
// led_bank_arbiter: shares one LED bank between three pattern requesters
// (client 0 = fault, 1 = status, 2 = idle animation). Fixed priority with a
// minimum-hold guard against preemption and a maximum-hold fairness timeout.
// All outputs are registered.
//
// Optional feature macro: LED_ARB_BLANK_EN
//   defined   -> the bank is blanked for one cycle on every ownership change
//   undefined -> ownership passes directly to the next winner with no gap
module led_bank_arbiter #(
    parameter int LED_W    = 5,
    parameter int MIN_HOLD = 4,
    parameter int MAX_HOLD = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [2:0]           req,
    input  logic [3*LED_W-1:0]   pattern,
    output logic [2:0]           grant,
    output logic [LED_W-1:0]     LEDs,
    output logic                 busy
);

    localparam int HOLD_W = $clog2(MAX_HOLD + 1);
    localparam logic [HOLD_W-1:0] MIN_LIM  = HOLD_W'(MIN_HOLD - 1);
    localparam logic [HOLD_W-1:0] MAX_LIM  = HOLD_W'(MAX_HOLD - 1);
    localparam logic [HOLD_W-1:0] HOLD_SAT = HOLD_W'(MAX_HOLD);

`ifdef LED_ARB_BLANK_EN
    localparam bit BLANK_EN = 1'b1;
`else
    localparam bit BLANK_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GRANT,
        ST_BLANK
    } state_e;

    state_e              state_q, state_d;
    logic [2:0]          grant_q, grant_d;
    logic [LED_W-1:0]    leds_q,  leds_d;
    logic                busy_q,  busy_d;
    logic [HOLD_W-1:0]   hold_q,  hold_d;
    logic [2:0]          fair_q,  fair_d;

    // One-hot winner: lowest set bit of (req minus masked owner), falling
    // back to the raw request vector when the mask would leave nothing.
    function automatic logic [2:0] pick(input logic [2:0] r, input logic [2:0] m);
        logic [2:0] cand;
        cand = r & ~m;
        if (cand == 3'b000) cand = r;
        return cand & (~cand + 3'd1);
    endfunction

    // Pattern slice of the client selected by a one-hot vector.
    function automatic logic [LED_W-1:0] pat_of(input logic [2:0] oh,
                                                input logic [3*LED_W-1:0] pat);
        logic [LED_W-1:0] r;
        r = '0;
        for (int i = 0; i < 3; i++) begin
            if (oh[i]) r |= pat[i*LED_W +: LED_W];
        end
        return r;
    endfunction

    logic        in_grant;
    logic        rel_hit, pre_hit, tmo_hit, leave;
    logic [2:0]  fair_eff;
    logic [2:0]  win;

    // Exit conditions of the current owner and the shared arbitration result.
    always_comb begin
        in_grant = (state_q == ST_GRANT);
        // grant_q - 1 is the mask of all indices above the owner in priority.
        rel_hit  = in_grant && ((req & grant_q) == 3'b000);
        pre_hit  = in_grant && ((req & (grant_q - 3'd1)) != 3'b000) && (hold_q >= MIN_LIM);
        tmo_hit  = in_grant && ((req & ~grant_q) != 3'b000) && (hold_q >= MAX_LIM);
        leave    = rel_hit || pre_hit || tmo_hit;
        // A timeout masks the outgoing owner for the arbitration it triggers.
        fair_eff = tmo_hit ? grant_q : fair_q;
        win      = pick(req, fair_eff);
    end

    // Next-state and registered-output logic.
    always_comb begin
        // NOTE: every target gets a default first, so no path can infer a latch.
        state_d = state_q;
        grant_d = grant_q;
        leds_d  = leds_q;
        busy_d  = busy_q;
        hold_d  = hold_q;
        fair_d  = fair_q;

        if (in_grant && !leave) begin
            hold_d = (hold_q == HOLD_SAT) ? hold_q : hold_q + HOLD_W'(1);
            leds_d = pat_of(grant_q, pattern);
        end else begin
            if (tmo_hit) fair_d = grant_q;

            if (in_grant && BLANK_EN) begin
                state_d = ST_BLANK;
                grant_d = 3'b000;
                leds_d  = '0;
                busy_d  = 1'b0;
                hold_d  = '0;
            end else if (req != 3'b000) begin
                state_d = ST_GRANT;
                grant_d = win;
                leds_d  = pat_of(win, pattern);
                busy_d  = 1'b1;
                hold_d  = '0;
                fair_d  = 3'b000;
            end else begin
                state_d = ST_IDLE;
                grant_d = 3'b000;
                leds_d  = '0;
                busy_d  = 1'b0;
                hold_d  = '0;
            end
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        // NOTE: non-blocking assignments keep every register sampling pre-edge values.
        if (!reset) begin
            state_q <= ST_IDLE;
            grant_q <= 3'b000;
            leds_q  <= '0;
            busy_q  <= 1'b0;
            hold_q  <= '0;
            fair_q  <= 3'b000;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            leds_q  <= leds_d;
            busy_q  <= busy_d;
            hold_q  <= hold_d;
            fair_q  <= fair_d;
        end
    end

    assign grant = grant_q;
    assign LEDs  = leds_q;
    assign busy  = busy_q;

endmodule
